// File: rtl/icache_boot_loader_if.sv
// Stream-in / Icache-write bundle for the boot loader.
// Valid/ready: a word transfers on a rising edge where in_valid and in_ready are
// both high; in_data/in_last must hold while in_valid is high and in_ready is low.
interface icache_boot_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  boot_start;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] boot_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  pc_running;
  logic                  boot_done;
  logic                  boot_err;
  logic [2:0]            dbg_state;

  modport master (
    output boot_start, in_valid, in_data, in_last,
    input  in_ready, wen, boot_addr, wdata, pc_running, boot_done, boot_err, dbg_state
  );

  modport slave (
    input  boot_start, in_valid, in_data, in_last,
    output in_ready, wen, boot_addr, wdata, pc_running, boot_done, boot_err, dbg_state
  );
endinterface

// File: rtl/icache_boot_loader.sv
// Streams an instruction image into consecutive Icache words, then hands the Icache to the PC.
// Optional trailing-checksum verification: define ICACHE_BOOT_CHECKSUM_EN.
module icache_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_NUM   = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  icache_boot_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
`ifdef ICACHE_BOOT_CHECKSUM_EN
    ,
    S_CSUM  = 3'd4,
    S_ERR   = 3'd5
`endif
  } state_t;

  // One extra bit so the count can reach ADDR_NUM without wrapping.
  localparam int              CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(ADDR_NUM - 1);

  state_t                state;
  logic [CW-1:0]         count;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pc_q;
  logic                  done_q;
  logic                  in_ready_c;
  logic                  accept;
  logic                  image_end;

`ifdef ICACHE_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  err_q;
  assign in_ready_c = (state == S_LOAD) || (state == S_CSUM);
`else
  assign in_ready_c = (state == S_LOAD);
`endif

  assign accept    = bus.in_valid & in_ready_c;
  assign image_end = bus.in_last | (count == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef ICACHE_BOOT_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      wen_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.boot_start) begin
            state <= S_LOAD;
            count <= '0;
`ifdef ICACHE_BOOT_CHECKSUM_EN
            sum_q <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
            wen_q   <= 1'b1;
            addr_q  <= count[ADDR_WIDTH-1:0];
            wdata_q <= bus.in_data;
            count   <= count + 1'b1;
`ifdef ICACHE_BOOT_CHECKSUM_EN
            sum_q   <= sum_q + bus.in_data;
            if (image_end) state <= S_CSUM;
`else
            if (image_end) state <= S_DRAIN;
`endif
          end
        end
        // Final write is on the Icache bus this cycle; it commits on the same
        // edge that hands addressing over to the PC.
        S_DRAIN: begin
          state  <= S_DONE;
          pc_q   <= 1'b1;
          done_q <= 1'b1;
        end
        S_DONE: begin
          if (bus.boot_start) begin
            state  <= S_LOAD;
            count  <= '0;
            pc_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef ICACHE_BOOT_CHECKSUM_EN
            sum_q  <= '0;
`endif
          end
        end
`ifdef ICACHE_BOOT_CHECKSUM_EN
        // The checksum word is consumed, never written; its in_last is don't-care.
        S_CSUM: begin
          if (accept) begin
            if (DATA_WIDTH'(sum_q + bus.in_data) == '0) begin
              state  <= S_DONE;
              pc_q   <= 1'b1;
              done_q <= 1'b1;
            end else begin
              state  <= S_ERR;
              err_q  <= 1'b1;
            end
          end
        end
        S_ERR: begin
          if (bus.boot_start) begin
            state <= S_LOAD;
            count <= '0;
            sum_q <= '0;
            err_q <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.wen        = wen_q;
  assign bus.boot_addr  = addr_q;
  assign bus.wdata      = wdata_q;
  assign bus.pc_running = pc_q;
  assign bus.boot_done  = done_q;
  assign bus.dbg_state  = state;
`ifdef ICACHE_BOOT_CHECKSUM_EN
  assign bus.boot_err   = err_q;
`else
  assign bus.boot_err   = 1'b0;
`endif

endmodule
